digit_vote_filter: RTL and testbench

Temporal majority-vote filter that sits directly downstream of the MNIST classifier stage. It consumes the per-frame `digit` / `digit_valid_output` result produced by cam2cnn, keeps a sliding history of the last DEPTH classifications and publishes a stable digit only when one class dominates the window. This removes frame-to-frame flicker on the 7-segment display and LEDs. Inputs share the VGA pixel clock domain with the classifier.

---
 rtl/digit_vote_filter_if.sv | 25 ++
 rtl/digit_vote_filter.sv | 202 ++++++++++++++++++++
 tb/tb_digit_vote_filter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_vote_filter_if.sv
// Classifier-result inputs and published-digit outputs of digit_vote_filter.
// master drives classifications and EOF; slave is the vote filter itself.
interface digit_vote_filter_if #(
    parameter int DEPTH = 8
);
    localparam int VC_W = $clog2(DEPTH + 1);

    logic            EOF;
    logic [3:0]      digit_in;
    logic            digit_in_valid;
    logic [3:0]      stable_digit;
    logic            stable_valid;
    logic [VC_W-1:0] vote_count;
    logic [6:0]      hex_seg;

    modport master (
        output EOF, digit_in, digit_in_valid,
        input  stable_digit, stable_valid, vote_count, hex_seg
    );

    modport slave (
        input  EOF, digit_in, digit_in_valid,
        output stable_digit, stable_valid, vote_count, hex_seg
    );
endinterface

// File: rtl/digit_vote_filter.sv
// Sliding-window majority vote over classifier results, publishing a stable digit.
// Define DIGIT_VOTE_SEG_EN to drive hex_seg from an internal active-low 7-segment encoder.
module digit_vote_filter #(
    parameter int DEPTH          = 8,
    parameter int MIN_VOTES      = 5,
    parameter int TIMEOUT_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    digit_vote_filter_if.slave bus
);
    localparam int VC_W = $clog2(DEPTH + 1);
    localparam logic [VC_W-1:0] MIN_VOTES_C = VC_W'(MIN_VOTES);
    localparam logic [7:0]      TIMEOUT_C   = 8'(TIMEOUT_FRAMES);

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

    state_t                state_q, state_d;
    logic [DEPTH-1:0]      hist_valid_q, hist_valid_d;
    logic [DEPTH-1:0][3:0] hist_digit_q, hist_digit_d;
    logic [3:0]            cand_q, cand_d;
    logic [3:0]            best_q, best_d;
    logic [VC_W-1:0]       best_cnt_q, best_cnt_d;
    logic                  rescan_q, rescan_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic                  eof_q;
    logic [3:0]            stable_digit_q, stable_digit_d;
    logic                  stable_valid_q, stable_valid_d;
    logic [VC_W-1:0]       vote_count_q, vote_count_d;

    logic                  push;
    logic                  in_ok;
    logic                  eof_rise;
    logic                  flush;
    logic [DEPTH-1:0]      match;
    logic [VC_W-1:0]       cand_cnt;

    assign push     = bus.digit_in_valid;
    assign in_ok    = (bus.digit_in <= 4'd9);
    assign eof_rise = bus.EOF & ~eof_q;
    // A push in the same cycle as the timeout cancels the flush.
    assign flush    = (frame_cnt_q == TIMEOUT_C) & ~push;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_valid_d[gi] = flush ? 1'b0 : (push ? in_ok        : hist_valid_q[gi]);
                assign hist_digit_d[gi] = flush ? 4'd0 : (push ? bus.digit_in : hist_digit_q[gi]);
            end else begin : g_tail
                assign hist_valid_d[gi] = flush ? 1'b0 : (push ? hist_valid_q[gi-1] : hist_valid_q[gi]);
                assign hist_digit_d[gi] = flush ? 4'd0 : (push ? hist_digit_q[gi-1] : hist_digit_q[gi]);
            end
            assign match[gi] = hist_valid_q[gi] && (hist_digit_q[gi] == cand_q);
        end
    endgenerate

    always_comb begin
        cand_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cand_cnt = cand_cnt + {{(VC_W-1){1'b0}}, match[i]};
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (push || flush) begin
            frame_cnt_d = 8'd0;
        end else if (eof_rise && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        cand_d         = cand_q;
        best_d         = best_q;
        best_cnt_d     = best_cnt_q;
        rescan_d       = rescan_q;
        stable_digit_d = stable_digit_q;
        stable_valid_d = stable_valid_q;
        vote_count_d   = vote_count_q;

        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d    = SCAN;
                    cand_d     = 4'd0;
                    best_d     = 4'd0;
                    best_cnt_d = '0;
                end
            end
            SCAN: begin
                if (push) begin
                    rescan_d = 1'b1;
                end
                // Strictly greater keeps the lowest digit on a tie.
                if (cand_cnt > best_cnt_q) begin
                    best_d     = cand_q;
                    best_cnt_d = cand_cnt;
                end
                cand_d = cand_q + 4'd1;
                if (cand_q == 4'd9) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                vote_count_d = best_cnt_q;
                if (best_cnt_q >= MIN_VOTES_C) begin
                    stable_digit_d = best_q;
                    stable_valid_d = 1'b1;
                end
                if (rescan_q || push) begin
                    state_d    = SCAN;
                    cand_d     = 4'd0;
                    best_d     = 4'd0;
                    best_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
                rescan_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d        = IDLE;
            rescan_d       = 1'b0;
            stable_digit_d = 4'd0;
            stable_valid_d = 1'b0;
            vote_count_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            hist_valid_q   <= '0;
            hist_digit_q   <= '0;
            cand_q         <= 4'd0;
            best_q         <= 4'd0;
            best_cnt_q     <= '0;
            rescan_q       <= 1'b0;
            frame_cnt_q    <= 8'd0;
            eof_q          <= 1'b0;
            stable_digit_q <= 4'd0;
            stable_valid_q <= 1'b0;
            vote_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            hist_valid_q   <= hist_valid_d;
            hist_digit_q   <= hist_digit_d;
            cand_q         <= cand_d;
            best_q         <= best_d;
            best_cnt_q     <= best_cnt_d;
            rescan_q       <= rescan_d;
            frame_cnt_q    <= frame_cnt_d;
            eof_q          <= bus.EOF;
            stable_digit_q <= stable_digit_d;
            stable_valid_q <= stable_valid_d;
            vote_count_q   <= vote_count_d;
        end
    end

    assign bus.stable_digit = stable_digit_q;
    assign bus.stable_valid = stable_valid_q;
    assign bus.vote_count   = vote_count_q;

`ifdef DIGIT_VOTE_SEG_EN
    logic [6:0] hex_seg_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            hex_seg_q <= 7'h7F;
        end else begin
            hex_seg_q <= stable_valid_q ? seg7(stable_digit_q) : 7'h7F;
        end
    end

    assign bus.hex_seg = hex_seg_q;
`else
    assign bus.hex_seg = 7'h7F;
`endif
endmodule

// File: tb/tb_digit_vote_filter.sv
// Directed-vector bench for digit_vote_filter: one task per scenario, inline checks.
module tb_digit_vote_filter;
    logic       clk = 1'b0;
    logic       rst;
    logic       eof;
    logic [3:0] d_in;
    logic       d_vld;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

`ifdef DIGIT_VOTE_SEG_EN
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
`else
    localparam logic [6:0] HEX_3 = 7'h7F;
    localparam logic [6:0] HEX_8 = 7'h7F;
    localparam logic [6:0] HEX_9 = 7'h7F;
`endif

    digit_vote_filter_if #(.DEPTH(8)) bus_a ();
    digit_vote_filter_if #(.DEPTH(8)) bus_t ();

    assign bus_a.EOF            = eof;
    assign bus_a.digit_in       = d_in;
    assign bus_a.digit_in_valid = d_vld;
    assign bus_t.EOF            = eof;
    assign bus_t.digit_in       = d_in;
    assign bus_t.digit_in_valid = d_vld;

    digit_vote_filter #(.DEPTH(8), .MIN_VOTES(5), .TIMEOUT_FRAMES(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    // Same stimulus, lower threshold, used for the tie-break scenario.
    digit_vote_filter #(.DEPTH(8), .MIN_VOTES(4), .TIMEOUT_FRAMES(30)) dut_tie (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] d);
        d_in  = d;
        d_vld = 1'b1;
        step(1);
        d_vld = 1'b0;
        $display("push digit=%0h t=%0t stable=%0d valid=%0b votes=%0d", d, $time, bus_a.stable_digit, bus_a.stable_valid, bus_a.vote_count);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        eof   = 1'b0;
        d_vld = 1'b0;
        d_in  = 4'd0;
        step(2);
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus_a.stable_digit !== 4'd0)  begin errors++; $display("FAIL rst_digit got %0d want 0", bus_a.stable_digit); end
        checks++; if (bus_a.stable_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %0b want 0", bus_a.stable_valid); end
        checks++; if (bus_a.vote_count !== 4'd0)    begin errors++; $display("FAIL rst_votes got %0d want 0", bus_a.vote_count); end
        checks++; if (bus_a.hex_seg !== 7'h7F)      begin errors++; $display("FAIL rst_hex got %0h want 7f", bus_a.hex_seg); end
    endtask

    task automatic test_majority();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(4'd3);
            step(99);
        end
        checks++; if (bus_a.stable_valid !== 1'b0) begin errors++; $display("FAIL maj4_valid got %0b want 0", bus_a.stable_valid); end
        checks++; if (bus_a.vote_count !== 4'd4)   begin errors++; $display("FAIL maj4_votes got %0d want 4", bus_a.vote_count); end
        push(4'd3);
        step(10);
        checks++; if (bus_a.stable_valid !== 1'b0) begin errors++; $display("FAIL maj_edge10_valid got %0b want 0", bus_a.stable_valid); end
        step(1);
        checks++; if (bus_a.stable_digit !== 4'd3) begin errors++; $display("FAIL maj_digit got %0d want 3", bus_a.stable_digit); end
        checks++; if (bus_a.stable_valid !== 1'b1) begin errors++; $display("FAIL maj_valid got %0b want 1", bus_a.stable_valid); end
        checks++; if (bus_a.vote_count !== 4'd5)   begin errors++; $display("FAIL maj_votes got %0d want 5", bus_a.vote_count); end
        checks++; if (bus_a.hex_seg !== 7'h7F)     begin errors++; $display("FAIL maj_hex_lag got %0h want 7f", bus_a.hex_seg); end
        step(1);
        checks++; if (bus_a.hex_seg !== HEX_3)     begin errors++; $display("FAIL maj_hex got %0h want %0h", bus_a.hex_seg, HEX_3); end
    endtask

    // Continues from test_majority's window of five 3s.
    task automatic test_hysteresis();
        for (int i = 0; i < 3; i++) begin
            push(4'd7);
            step(20);
        end
        checks++; if (bus_a.vote_count !== 4'd5)   begin errors++; $display("FAIL hys_53_votes got %0d want 5", bus_a.vote_count); end
        push(4'd7);
        step(20);
        checks++; if (bus_a.vote_count !== 4'd4)   begin errors++; $display("FAIL hys_44_votes got %0d want 4", bus_a.vote_count); end
        checks++; if (bus_a.stable_digit !== 4'd3) begin errors++; $display("FAIL hys_hold_digit got %0d want 3", bus_a.stable_digit); end
        checks++; if (bus_a.stable_valid !== 1'b1) begin errors++; $display("FAIL hys_hold_valid got %0b want 1", bus_a.stable_valid); end
        push(4'd7);
        step(11);
        checks++; if (bus_a.vote_count !== 4'd5)   begin errors++; $display("FAIL hys_35_votes got %0d want 5", bus_a.vote_count); end
        checks++; if (bus_a.stable_digit !== 4'd7) begin errors++; $display("FAIL hys_new_digit got %0d want 7", bus_a.stable_digit); end
    endtask

    task automatic test_tie_break();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(4'd6);
            step(15);
        end
        checks++; if (bus_t.stable_digit !== 4'd6) begin errors++; $display("FAIL tie_pre_digit got %0d want 6", bus_t.stable_digit); end
        for (int i = 0; i < 4; i++) begin
            push(4'd2);
            step(15);
        end
        checks++; if (bus_t.stable_digit !== 4'd2) begin errors++; $display("FAIL tie_digit got %0d want 2", bus_t.stable_digit); end
        checks++; if (bus_t.stable_valid !== 1'b1) begin errors++; $display("FAIL tie_valid got %0b want 1", bus_t.stable_valid); end
        checks++; if (bus_t.vote_count !== 4'd4)   begin errors++; $display("FAIL tie_votes got %0d want 4", bus_t.vote_count); end
        checks++; if (bus_a.stable_valid !== 1'b0) begin errors++; $display("FAIL tie_min5_valid got %0b want 0", bus_a.stable_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(4'd8);
            step(15);
        end
        checks++; if (bus_a.stable_digit !== 4'd8) begin errors++; $display("FAIL to_pre_digit got %0d want 8", bus_a.stable_digit); end
        for (int i = 0; i < 29; i++) begin
            eof = 1'b1;
            step(1);
            eof = 1'b0;
            step(1);
        end
        checks++; if (bus_a.stable_valid !== 1'b1) begin errors++; $display("FAIL to_29_valid got %0b want 1", bus_a.stable_valid); end
        eof = 1'b1;
        step(1);
        checks++; if (bus_a.stable_valid !== 1'b1) begin errors++; $display("FAIL to_30_edge_valid got %0b want 1", bus_a.stable_valid); end
        eof = 1'b0;
        step(1);
        $display("timeout flush t=%0t", $time);
        checks++; if (bus_a.stable_valid !== 1'b0) begin errors++; $display("FAIL to_valid got %0b want 0", bus_a.stable_valid); end
        checks++; if (bus_a.stable_digit !== 4'd0) begin errors++; $display("FAIL to_digit got %0d want 0", bus_a.stable_digit); end
        checks++; if (bus_a.vote_count !== 4'd0)   begin errors++; $display("FAIL to_votes got %0d want 0", bus_a.vote_count); end
        checks++; if (bus_a.hex_seg !== HEX_8)     begin errors++; $display("FAIL to_hex_lag got %0h want %0h", bus_a.hex_seg, HEX_8); end
        step(1);
        checks++; if (bus_a.hex_seg !== 7'h7F)     begin errors++; $display("FAIL to_hex got %0h want 7f", bus_a.hex_seg); end
    endtask

    task automatic test_rescan();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(4'd2);
            step(15);
        end
        push(4'd2);
        step(4);
        push(4'd2);
        step(4);
        step(1);
        checks++; if (bus_a.vote_count !== 4'd4)   begin errors++; $display("FAIL rs_edge10_votes got %0d want 4", bus_a.vote_count); end
        step(1);
        checks++; if (bus_a.vote_count !== 4'd5)   begin errors++; $display("FAIL rs_edge11_votes got %0d want 5", bus_a.vote_count); end
        checks++; if (bus_a.stable_valid !== 1'b1) begin errors++; $display("FAIL rs_edge11_valid got %0b want 1", bus_a.stable_valid); end
        step(10);
        checks++; if (bus_a.vote_count !== 4'd5)   begin errors++; $display("FAIL rs_edge21_votes got %0d want 5", bus_a.vote_count); end
        step(1);
        checks++; if (bus_a.vote_count !== 4'd6)   begin errors++; $display("FAIL rs_edge22_votes got %0d want 6", bus_a.vote_count); end
        checks++; if (bus_a.stable_digit !== 4'd2) begin errors++; $display("FAIL rs_digit got %0d want 2", bus_a.stable_digit); end
    endtask

    task automatic test_invalid();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(4'hC);
            step(12);
        end
        checks++; if (bus_a.stable_digit !== 4'd0) begin errors++; $display("FAIL inv_digit got %0d want 0", bus_a.stable_digit); end
        checks++; if (bus_a.stable_valid !== 1'b0) begin errors++; $display("FAIL inv_valid got %0b want 0", bus_a.stable_valid); end
        checks++; if (bus_a.vote_count !== 4'd0)   begin errors++; $display("FAIL inv_votes got %0d want 0", bus_a.vote_count); end
        checks++; if (bus_a.hex_seg !== 7'h7F)     begin errors++; $display("FAIL inv_hex got %0h want 7f", bus_a.hex_seg); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_in  = 4'd9;
        d_vld = 1'b1;
        step(5);
        d_vld = 1'b0;
        $display("burst of 5 x digit 9 t=%0t", $time);
        step(6);
        checks++; if (bus_a.stable_valid !== 1'b0) begin errors++; $display("FAIL b2b_edge10_valid got %0b want 0", bus_a.stable_valid); end
        step(1);
        checks++; if (bus_a.stable_digit !== 4'd9) begin errors++; $display("FAIL b2b_digit got %0d want 9", bus_a.stable_digit); end
        checks++; if (bus_a.vote_count !== 4'd5)   begin errors++; $display("FAIL b2b_votes got %0d want 5", bus_a.vote_count); end
        step(11);
        checks++; if (bus_a.vote_count !== 4'd5)   begin errors++; $display("FAIL b2b_rescan_votes got %0d want 5", bus_a.vote_count); end
        checks++; if (bus_a.hex_seg !== HEX_9)     begin errors++; $display("FAIL b2b_hex got %0h want %0h", bus_a.hex_seg, HEX_9); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        d_in  = 4'd4;
        d_vld = 1'b1;
        step(5);
        d_vld = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        $display("reset mid-scan t=%0t", $time);
        step(10);
        checks++; if (bus_a.stable_digit !== 4'd0) begin errors++; $display("FAIL mrst_digit got %0d want 0", bus_a.stable_digit); end
        checks++; if (bus_a.stable_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0b want 0", bus_a.stable_valid); end
        checks++; if (bus_a.vote_count !== 4'd0)   begin errors++; $display("FAIL mrst_votes got %0d want 0", bus_a.vote_count); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        eof   = 1'b0;
        d_vld = 1'b0;
        d_in  = 4'd0;
        test_reset();
        test_majority();
        test_hysteresis();
        test_tie_break();
        test_timeout();
        test_rescan();
        test_invalid();
        test_back_to_back();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
